// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor types and helpers
package bp_pkg;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} bp_state_e;

   // Saturating +/-1; callers pass the counter ceiling and keep only their own width.
   function automatic logic [31:0] sat_step(input logic [31:0] cnt, input logic up,
                                            input logic [31:0] max_val);
      logic [31:0] res;
      res = cnt;
      if (up) begin
         if (cnt != max_val) res = cnt + 32'd1;
      end else begin
         if (cnt != 32'd0) res = cnt - 32'd1;
      end
      return res;
   endfunction

   // Word-aligned PC xor LSB-aligned history; callers truncate to their index width.
   function automatic logic [31:0] bp_hash(input logic [31:0] pc, input logic [31:0] hist);
      return {2'b00, pc[31:2]} ^ hist;
   endfunction

endpackage

// File: rtl/gshare_bht_if.sv
// rtl/gshare_bht_if.sv - lookup/update/status bundle between fetch, execute and the predictor
interface gshare_bht_if #(parameter int HIST_W = 8);

   logic              lookup_valid;
   logic [31:0]       lookup_pc;
   logic              predict_taken;
   logic [HIST_W-1:0] predict_ghr;
   logic              update_valid;
   logic [31:0]       update_pc;
   logic              update_taken;
   logic [HIST_W-1:0] update_ghr;
   logic              update_mispred;
   logic              init_busy;

   modport master (
      output lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
             update_ghr, update_mispred,
      input  predict_taken, predict_ghr, init_busy
   );

   modport slave (
      input  lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
             update_ghr, update_mispred,
      output predict_taken, predict_ghr, init_busy
   );

endinterface

// File: rtl/bht_sat_ctr_table.sv
// rtl/bht_sat_ctr_table.sv - saturating counter array, one async read port and one RMW write port
module bht_sat_ctr_table
   import bp_pkg::*;
#(
   parameter int IDX_W    = 12,
   parameter int CNT_W    = 2,
   parameter int CNT_INIT = 1
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [CNT_W-1:0] rd_cnt,
   input  logic             wr_en,
   input  logic             wr_init,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_up
);

   localparam int               DEPTH   = 2 ** IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0] wr_data_d;

   assign rd_cnt = mem_q[rd_idx];

   // The init sweep overrides the read-modify-write path.
   always_comb begin
      wr_data_d = mem_q[wr_idx];
      if (wr_init) wr_data_d = CNT_W'(CNT_INIT);
      else         wr_data_d = CNT_W'(sat_step(32'(mem_q[wr_idx]), wr_up, 32'(CNT_MAX)));
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wr_data_d;
   end

endmodule

// File: rtl/gshare_bht.sv
// rtl/gshare_bht.sv - branch direction predictor; GSHARE_HIST_EN selects gshare, else bimodal
// Holds the init-sweep FSM, sweep pointer, speculative history and index hashing.
module gshare_bht
   import bp_pkg::*;
#(
   parameter int IDX_W    = 12,
   parameter int CNT_W    = 2,
   parameter int HIST_W   = 8,
   parameter int CNT_INIT = 1
) (
   input  logic           clk,
   input  logic           rst,
   gshare_bht_if.slave    bus
);

   bp_state_e        state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] lk_idx, up_idx, wr_idx;
   logic [CNT_W-1:0] lk_cnt;
   logic             init_busy, run, wr_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == INIT && ptr_q == '1) state_d = RUN;
   end

   always_comb begin
      init_busy = (state_q == INIT);
      run       = (state_q == RUN);
   end

   always_comb begin
      ptr_d = ptr_q;
      if (init_busy) ptr_d = ptr_q + IDX_W'(1);
   end

`ifdef GSHARE_HIST_EN
   logic [HIST_W-1:0] ghr_q, ghr_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ghr_q <= '0;
      else      ghr_q <= ghr_d;
   end

   // Mispredict recovery wins over the speculative shift of a same-cycle lookup.
   always_comb begin
      ghr_d = ghr_q;
      if (run) begin
         if (bus.update_valid && bus.update_mispred)
            ghr_d = {bus.update_ghr[HIST_W-2:0], bus.update_taken};
         else if (bus.lookup_valid)
            ghr_d = {ghr_q[HIST_W-2:0], bus.predict_taken};
      end
   end

   assign lk_idx          = IDX_W'(bp_hash(bus.lookup_pc, 32'(ghr_q)));
   assign up_idx          = IDX_W'(bp_hash(bus.update_pc, 32'(bus.update_ghr)));
   assign bus.predict_ghr = ghr_q;
`else
   logic unused_bimodal;

   assign lk_idx          = IDX_W'(bp_hash(bus.lookup_pc, 32'd0));
   assign up_idx          = IDX_W'(bp_hash(bus.update_pc, 32'd0));
   assign bus.predict_ghr = '0;
   assign unused_bimodal  = ^{bus.lookup_valid, bus.update_mispred, bus.update_ghr};
`endif

   assign wr_en             = init_busy | (run & bus.update_valid);
   assign wr_idx            = init_busy ? ptr_q : up_idx;
   assign bus.init_busy     = init_busy;
   assign bus.predict_taken = run & lk_cnt[CNT_W-1];

   bht_sat_ctr_table #(
      .IDX_W    (IDX_W),
      .CNT_W    (CNT_W),
      .CNT_INIT (CNT_INIT)
   ) u_table (
      .clk     (clk),
      .rd_idx  (lk_idx),
      .rd_cnt  (lk_cnt),
      .wr_en   (wr_en),
      .wr_init (init_busy),
      .wr_idx  (wr_idx),
      .wr_up   (bus.update_taken)
   );

endmodule

// File: tb/tb_gshare_bht.sv
// tb/tb_gshare_bht.sv - directed bench for gshare_bht (gshare or bimodal per GSHARE_HIST_EN)
module tb_gshare_bht;

   localparam int IDX_W  = 12;
   localparam int CNT_W  = 2;
   localparam int HIST_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   gshare_bht_if #(.HIST_W(HIST_W)) bus ();

   gshare_bht #(
      .IDX_W    (IDX_W),
      .CNT_W    (CNT_W),
      .HIST_W   (HIST_W),
      .CNT_INIT (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus.lookup_valid   = 1'b0;
      bus.lookup_pc      = 32'h0;
      bus.update_valid   = 1'b0;
      bus.update_pc      = 32'h0;
      bus.update_taken   = 1'b0;
      bus.update_ghr     = '0;
      bus.update_mispred = 1'b0;
   endtask

   function automatic logic [31:0] ctr(input int idx);
      return 32'(dut.u_table.mem_q[idx]);
   endfunction

   task automatic wait_init(output int n);
      n = 0;
      do begin
         tick();
         n++;
         if (n == 10) begin
            check("init_pred", 32'(bus.predict_taken), 0);
            check("init_ghr_held", 32'(bus.predict_ghr), 0);
         end
      end while (bus.init_busy && n < 5000);
   endtask

   task automatic count_bad(output int bad);
      bad = 0;
      for (int i = 0; i < 2 ** IDX_W; i++)
         if (ctr(i) != 32'd1) bad++;
   endtask

   task automatic train(input logic [31:0] pc, input logic [HIST_W-1:0] g, input logic tk, input int reps);
      bus.update_valid   = 1'b1;
      bus.update_pc      = pc;
      bus.update_ghr     = g;
      bus.update_taken   = tk;
      bus.update_mispred = 1'b0;
      repeat (reps) tick();
      idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, bad;
      int up_exp[4]   = '{2, 3, 3, 3};
      int down_exp[4] = '{2, 1, 0, 0};
      logic [HIST_W-1:0] g5;

      idle();
      repeat (3) tick();
      check("rst_busy", 32'(bus.init_busy), 1);
      check("rst_pred", 32'(bus.predict_taken), 0);
      check("rst_ghr", 32'(bus.predict_ghr), 0);

      // Traffic during the sweep must neither move history nor corrupt the table.
      bus.lookup_valid   = 1'b1;
      bus.lookup_pc      = 32'h100;
      bus.update_valid   = 1'b1;
      bus.update_mispred = 1'b1;
      bus.update_ghr     = 8'h05;
      bus.update_taken   = 1'b1;
      bus.update_pc      = 32'h100;
      rst = 1'b1;
      wait_init(n);
      check("init_cycles", n, 4096);
      idle();
      #1;
      check("post_init_ghr", 32'(bus.predict_ghr), 0);
      count_bad(bad);
      check("init_all_ones", bad, 0);

      // Counter saturation at idx 0x40 with zero history.
      bus.lookup_pc = 32'h100;
      #1;
      check("pred_weak_nt", 32'(bus.predict_taken), 0);
      bus.update_valid = 1'b1;
      bus.update_pc    = 32'h100;
      bus.update_taken = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ctr_inc", ctr('h40), up_exp[i]);
         if (i == 0) check("pred_after_inc", 32'(bus.predict_taken), 1);
      end
      bus.update_taken = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ctr_dec", ctr('h40), down_exp[i]);
      end
      bus.update_valid = 1'b0;
      #1;
      check("pred_after_dec", 32'(bus.predict_taken), 0);
      idle();

`ifdef GSHARE_HIST_EN
      train(32'h200, 8'h00, 1'b1, 2);
      train(32'h300, 8'h01, 1'b1, 2);
      begin
         logic [31:0] pcs[3]   = '{32'h200, 32'h300, 32'h400};
         int          ghrs[3]  = '{'h00, 'h01, 'h03};
         int          preds[3] = '{1, 1, 0};
         for (int i = 0; i < 3; i++) begin
            bus.lookup_valid = 1'b1;
            bus.lookup_pc    = pcs[i];
            #1;
            check("spec_ghr", 32'(bus.predict_ghr), ghrs[i]);
            check("spec_pred", 32'(bus.predict_taken), preds[i]);
            tick();
         end
      end
      idle();
      #1;
      check("ghr_after_lookups", 32'(bus.predict_ghr), 'h06);

      bus.lookup_valid   = 1'b1;
      bus.lookup_pc      = 32'h500;
      bus.update_valid   = 1'b1;
      bus.update_mispred = 1'b1;
      bus.update_ghr     = 8'h05;
      bus.update_taken   = 1'b1;
      bus.update_pc      = 32'h800;
      #1;
      check("recov_pre_ghr", 32'(bus.predict_ghr), 'h06);
      tick();
      idle();
      #1;
      check("recov_ghr", 32'(bus.predict_ghr), 'h0B);
      g5 = 8'h0B;
`else
      bus.lookup_valid = 1'b1;
      bus.lookup_pc    = 32'h200;
      tick();
      tick();
      check("bimodal_ghr_lookup", 32'(bus.predict_ghr), 0);
      bus.update_valid   = 1'b1;
      bus.update_mispred = 1'b1;
      bus.update_ghr     = 8'h05;
      bus.update_taken   = 1'b1;
      bus.update_pc      = 32'h2000;
      tick();
      idle();
      #1;
      check("bimodal_ghr_recov", 32'(bus.predict_ghr), 0);
      check("bimodal_upd_ghr_ignored", ctr('h800), 2);
      g5 = 8'h00;
`endif

      // Same-index lookup and update: old counter this cycle, new value next cycle.
      bus.lookup_pc    = 32'h1000;
      bus.update_valid = 1'b1;
      bus.update_pc    = 32'h1000;
      bus.update_ghr   = g5;
      bus.update_taken = 1'b1;
      #1;
      check("same_idx_old", 32'(bus.predict_taken), 0);
      tick();
      bus.update_valid = 1'b0;
      #1;
      check("same_idx_new", 32'(bus.predict_taken), 1);
      check("same_idx_ctr", ctr(32'h400 ^ 32'(g5)), 2);
      idle();

      // Reset restart mid-sweep; entry 0xFFF lies beyond the restart point.
      train(32'h3FFC, 8'h00, 1'b1, 2);
      check("pre_reset_ctr", ctr('hFFF), 3);
      rst = 1'b0;
      #2;
      check("reset_busy", 32'(bus.init_busy), 1);
      rst = 1'b1;
      repeat (2000) tick();
      check("mid_sweep_busy", 32'(bus.init_busy), 1);
      rst = 1'b0;
      #2;
      check("restart_busy", 32'(bus.init_busy), 1);
      rst = 1'b1;
      wait_init(n);
      check("restart_cycles", n, 4096);
      count_bad(bad);
      check("restart_all_ones", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
